vdp_vram_arbiter: RTL and testbench

VDP_VRAM_ARBITER -- requirements
Module: vdp_vram_arbiter

---
 rtl/vdp_pkg.sv | 32 +++
 rtl/vdp_arb_starve_timer.sv | 27 ++
 rtl/vdp_vram_arbiter.sv | 126 ++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared VDP types and constants: requester ids, beam phase, VRAM geometry.
package vdp_pkg;

    localparam int VRAM_AW         = 14;
    localparam int LINE_ACTIVE_END = 256;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_BG,
        REQ_SPRITE,
        REQ_CPU
    } req_e;

    typedef enum logic {
        DISPLAY,
        BLANK
    } phase_e;

    // {cpu, sprite, bg} one-hot strobe for a requester id
    function automatic logic [2:0] req_onehot(input req_e r);
        logic [2:0] oh;
        oh = 3'b000;
        case (r)
            REQ_BG:     oh = 3'b001;
            REQ_SPRITE: oh = 3'b010;
            REQ_CPU:    oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/vdp_arb_starve_timer.sv
// Counts consecutive denied CPU request cycles and flags promotion at LIMIT.
module vdp_arb_starve_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cpu_req,
    input  logic cpu_win,
    output logic promote
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (!cpu_req || cpu_win)
            cnt_q <= '0;
        else if (cnt_q != CW'(LIMIT))
            cnt_q <= cnt_q + 1'b1;
    end

    assign promote = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Three-way VRAM arbiter (bg, sprite, cpu) with beam-phase priority.
// Define VDP_ARB_STARVE_GUARD_EN to promote a starved CPU after STARVE_LIMIT denials.
module vdp_vram_arbiter
    import vdp_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [9:0]         pixel_x,
    input  logic               bg_req,
    input  logic               sprite_req,
    input  logic               cpu_req,
    input  logic [VRAM_AW-1:0] bg_addr,
    input  logic [VRAM_AW-1:0] sprite_addr,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic               cpu_we,
    input  logic [7:0]         cpu_wdata,
    output logic               bg_gnt,
    output logic               sprite_gnt,
    output logic               cpu_gnt,
    output logic               bg_rvalid,
    output logic               sprite_rvalid,
    output logic               cpu_rvalid,
    output logic [7:0]         rdata,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_we,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    phase_e             phase_q, phase_d;
    req_e               win;
    req_e               owner_q;
    logic               promote;
    logic               cpu_wr;
    logic [2:0]         gnt_q, rv_q;
    logic [VRAM_AW-1:0] addr_q, sel_addr;
    logic               we_q;
    logic [7:0]         wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= DISPLAY;
        else        phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            DISPLAY: if (pixel_x == 10'(LINE_ACTIVE_END)) phase_d = BLANK;
            BLANK:   if (pixel_x == 10'd0)                phase_d = DISPLAY;
            default: phase_d = DISPLAY;
        endcase
    end

`ifdef VDP_ARB_STARVE_GUARD_EN
    vdp_arb_starve_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .cpu_req (cpu_req),
        .cpu_win (win == REQ_CPU),
        .promote (promote)
    );
`else
    assign promote = 1'b0;
`endif

    // Priority follows the registered phase, so a transition cycle still uses the old order
    always_comb begin
        win = REQ_NONE;
        if (promote && cpu_req)
            win = REQ_CPU;
        else if (phase_q == DISPLAY) begin
            if      (bg_req)     win = REQ_BG;
            else if (sprite_req) win = REQ_SPRITE;
            else if (cpu_req)    win = REQ_CPU;
        end else begin
            if      (sprite_req) win = REQ_SPRITE;
            else if (bg_req)     win = REQ_BG;
            else if (cpu_req)    win = REQ_CPU;
        end
    end

    always_comb begin
        sel_addr = addr_q;
        case (win)
            REQ_BG:     sel_addr = bg_addr;
            REQ_SPRITE: sel_addr = sprite_addr;
            REQ_CPU:    sel_addr = cpu_addr;
            default:    sel_addr = addr_q;
        endcase
    end

    assign cpu_wr = (win == REQ_CPU) && cpu_we;

    // owner_q tags the read in flight; rv_q fires one cycle later with the VRAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            rv_q    <= '0;
            owner_q <= REQ_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            gnt_q   <= req_onehot(win);
            rv_q    <= req_onehot(owner_q);
            owner_q <= cpu_wr ? REQ_NONE : win;
            addr_q  <= sel_addr;
            we_q    <= cpu_wr;
            if (cpu_wr) wdata_q <= cpu_wdata;
        end
    end

    assign {cpu_gnt, sprite_gnt, bg_gnt}          = gnt_q;
    assign {cpu_rvalid, sprite_rvalid, bg_rvalid} = rv_q;
    assign vram_addr  = addr_q;
    assign vram_we    = we_q;
    assign vram_wdata = wdata_q;
    assign rdata      = vram_rdata;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for vdp_vram_arbiter with a one-cycle-latency VRAM model.
module tb_vdp_vram_arbiter;
    import vdp_pkg::*;

`ifdef VDP_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic               clk, rst_n;
    logic [9:0]         pixel_x;
    logic               bg_req, sprite_req, cpu_req, cpu_we;
    logic [VRAM_AW-1:0] bg_addr, sprite_addr, cpu_addr;
    logic [7:0]         cpu_wdata;
    logic               bg_gnt, sprite_gnt, cpu_gnt;
    logic               bg_rvalid, sprite_rvalid, cpu_rvalid;
    logic [7:0]         rdata, vram_wdata, vram_rdata;
    logic [VRAM_AW-1:0] vram_addr;
    logic               vram_we;

    int errors = 0;
    int checks = 0;

    vdp_vram_arbiter #(.STARVE_LIMIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x),
        .bg_req(bg_req), .sprite_req(sprite_req), .cpu_req(cpu_req),
        .bg_addr(bg_addr), .sprite_addr(sprite_addr), .cpu_addr(cpu_addr),
        .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .bg_gnt(bg_gnt), .sprite_gnt(sprite_gnt), .cpu_gnt(cpu_gnt),
        .bg_rvalid(bg_rvalid), .sprite_rvalid(sprite_rvalid), .cpu_rvalid(cpu_rvalid),
        .rdata(rdata), .vram_addr(vram_addr), .vram_we(vram_we),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations return a fixed address-derived pattern
    function automatic logic [7:0] pat(input logic [VRAM_AW-1:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    logic [7:0] mem [0:(1<<VRAM_AW)-1];
    bit         written [0:(1<<VRAM_AW)-1];

    always @(posedge clk) begin
        vram_rdata <= written[vram_addr] ? mem[vram_addr] : pat(vram_addr);
        if (vram_we) begin
            mem[vram_addr]     <= vram_wdata;
            written[vram_addr] <= 1'b1;
        end
    end

    wire [2:0] gnts = {cpu_gnt, sprite_gnt, bg_gnt};
    wire [2:0] rvs  = {cpu_rvalid, sprite_rvalid, bg_rvalid};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic               exp_cpu, prev_cpu;
        logic [VRAM_AW-1:0] prev_addr;
        rst_n = 1'b0; pixel_x = '0;
        bg_req = 0; sprite_req = 0; cpu_req = 0; cpu_we = 0;
        bg_addr = '0; sprite_addr = '0; cpu_addr = '0; cpu_wdata = '0;
        prev_cpu = 0; prev_addr = '0;

        tick; tick;
        chk("rst_gnt",   32'(gnts), 32'h0);
        chk("rst_rv",    32'(rvs), 32'h0);
        chk("rst_we",    32'(vram_we), 32'h0);
        chk("rst_addr",  32'(vram_addr), 32'h0);
        chk("rst_wdata", 32'(vram_wdata), 32'h0);
        rst_n = 1'b1;

        // DISPLAY: bg beats sprite, sprite served next cycle
        pixel_x = 10'd100;
        bg_req = 1; bg_addr = 14'h0123; sprite_req = 1; sprite_addr = 14'h0456;
        tick;
        chk("disp_gnt_bg",  32'(gnts), 32'b001);
        chk("disp_addr_bg", 32'(vram_addr), 32'h0123);
        bg_req = 0;
        tick;
        chk("disp_gnt_sp",   32'(gnts), 32'b010);
        chk("disp_rv_bg",    32'(rvs), 32'b001);
        chk("disp_rdata_bg", 32'(rdata), 32'(pat(14'h0123)));
        sprite_req = 0;
        tick;
        chk("disp_rv_sp",    32'(rvs), 32'b010);
        chk("disp_rdata_sp", 32'(rdata), 32'(pat(14'h0456)));
        chk("idle_gnt",      32'(gnts), 32'h0);
        chk("idle_we",       32'(vram_we), 32'h0);
        chk("idle_addr_hold", 32'(vram_addr), 32'h0456);
        tick;
        chk("idle_rv", 32'(rvs), 32'h0);

        // Phase switch at pixel_x==256 uses old order that cycle, BLANK order after
        pixel_x = 10'd256; bg_req = 1; sprite_req = 1;
        bg_addr = 14'h0200; sprite_addr = 14'h0300;
        tick;
        chk("edge256_bg", 32'(gnts), 32'b001);
        pixel_x = 10'd257;
        tick;
        chk("blank_sp_first", 32'(gnts), 32'b010);
        chk("blank_rv_bg",    32'(rvs), 32'b001);
        sprite_req = 0;
        tick;
        chk("blank_bg",    32'(gnts), 32'b001);
        chk("blank_rv_sp", 32'(rvs), 32'b010);
        bg_req = 0;
        pixel_x = 10'd0;
        tick;
        pixel_x = 10'd1; bg_req = 1; sprite_req = 1;
        tick;
        chk("redisplay_bg", 32'(gnts), 32'b001);
        bg_req = 0; sprite_req = 0;
        tick; tick;

        // CPU write: one-cycle strobe, no rvalid; then read it back
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h3F00; cpu_wdata = 8'hA5;
        tick;
        chk("wr_gnt",   32'(gnts), 32'b100);
        chk("wr_we",    32'(vram_we), 32'h1);
        chk("wr_addr",  32'(vram_addr), 32'h3F00);
        chk("wr_wdata", 32'(vram_wdata), 32'hA5);
        cpu_req = 0; cpu_we = 0;
        tick;
        chk("wr_we_once", 32'(vram_we), 32'h0);
        chk("wr_no_rv1",  32'(rvs), 32'h0);
        tick;
        chk("wr_no_rv2", 32'(rvs), 32'h0);
        cpu_req = 1;
        tick;
        chk("rd_cpu_gnt", 32'(gnts), 32'b100);
        chk("rd_cpu_we",  32'(vram_we), 32'h0);
        cpu_req = 0;
        tick;
        chk("rd_cpu_rv",    32'(rvs), 32'b100);
        chk("rd_cpu_rdata", 32'(rdata), 32'hA5);
        tick;

        // bg and cpu held: back-to-back bg grants; guard promotes cpu after 16 denials
        bg_req = 1; cpu_req = 1; cpu_addr = 14'h0050;
        for (int i = 0; i < 20; i++) begin
            bg_addr = 14'(16'h0100 + i);
            tick;
            exp_cpu = GUARD && (i == 16);
            chk($sformatf("hold_gnt_%0d", i), 32'(gnts), exp_cpu ? 32'b100 : 32'b001);
            if (i > 0) begin
                chk($sformatf("hold_rv_%0d", i), 32'(rvs), prev_cpu ? 32'b100 : 32'b001);
                chk($sformatf("hold_rdata_%0d", i), 32'(rdata),
                    32'(pat(prev_cpu ? 14'h0050 : prev_addr)));
            end
            prev_cpu  = exp_cpu;
            prev_addr = bg_addr;
        end
        bg_req = 0; cpu_req = 0;
        tick; tick;

        // Reset in the cycle after a read grant kills the pending read
        bg_req = 1; bg_addr = 14'h0A0A;
        tick;
        chk("rstmid_gnt", 32'(gnts), 32'b001);
        bg_req = 0; rst_n = 0;
        #1;
        chk("rstmid_gnt0",  32'(gnts), 32'h0);
        chk("rstmid_we",    32'(vram_we), 32'h0);
        chk("rstmid_addr",  32'(vram_addr), 32'h0);
        chk("rstmid_wdata", 32'(vram_wdata), 32'h0);
        tick;
        chk("rstmid_rv_held", 32'(rvs), 32'h0);
        rst_n = 1;
        tick;
        chk("rstmid_rv_after", 32'(rvs), 32'h0);
        sprite_req = 1; sprite_addr = 14'h0777;
        tick;
        chk("post_rst_gnt",  32'(gnts), 32'b010);
        chk("post_rst_addr", 32'(vram_addr), 32'h0777);
        sprite_req = 0;
        tick;
        chk("post_rst_rv",    32'(rvs), 32'b010);
        chk("post_rst_rdata", 32'(rdata), 32'(pat(14'h0777)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
